// File: rtl/router_pkg.sv
// Shared definitions for the router datapath register stage.
// Provides default bus widths, the check-mode enum and the per-word check step.
package router_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned LEN_W     = DATA_W - ADDR_W;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    typedef enum logic {
        CHK_XOR  = 1'b0,
        CHK_CRC8 = 1'b1
    } chk_mode_e;

    // One accumulation step: XOR parity, or CRC-8 (init 0, MSB-first) over one byte.
    function automatic logic [7:0] chk_next(chk_mode_e mode, logic [7:0] acc, logic [7:0] word);
        logic [7:0] c;
        c = acc ^ word;
        if (mode == CHK_CRC8) begin
            for (int i = 0; i < 8; i++) begin
                c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator: folds header and payload words into chk_q and
// compares the running check against the trailing check word.
// Ports:
//   clock, resetn  clock / async active-low reset
//   clr            start of packet, clears the accumulator
//   lfd            seed accumulator with the header
//   upd            fold data into the accumulator
//   hdr, data      header word / payload word
//   word           check word to compare against
//   mismatch_c     combinational: chk_q != word
module router_chk_acc #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHK_MODE = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              lfd,
    input  logic              upd,
    input  logic [DATA_W-1:0] hdr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] word,
    output logic              mismatch_c
);
    import router_pkg::*;

    logic [DATA_W-1:0] chk_q;
    logic [DATA_W-1:0] chk_d;

    // CRC mode is only meaningful for 8-bit words; XOR works at any width.
    function automatic logic [DATA_W-1:0] step(logic [DATA_W-1:0] acc, logic [DATA_W-1:0] w);
        if (CHK_MODE == 1) begin
            return DATA_W'(chk_next(CHK_CRC8, 8'(acc), 8'(w)));
        end
        return acc ^ w;
    endfunction

    // Next accumulator value; a new packet overrides everything else.
    always_comb begin
        chk_d = chk_q;
        if (clr) begin
            chk_d = '0;
        end else if (lfd) begin
            chk_d = step('0, hdr);
        end else if (upd) begin
            chk_d = step(chk_q, data);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign mismatch_c = (chk_q != word);

endmodule

// File: rtl/router_reg_param.sv
// Datapath register stage of the 1x3 router: latches the header, steers
// header / payload / held word onto dout, checks the packet against its
// trailing check word and its header length, and counts bad packets.
// Ports:
//   clock, resetn       clock / async active-low reset
//   pkt_valid, data_in  incoming packet stream
//   fifo_full           selected output FIFO is full
//   rst_int_reg         clears low_pkt_valid
//   detect_add, lfd_state, ld_state, full_state, laf_state  input FSM state flags
//   dout                word to FIFO
//   parity_done         check word compared, err/len_err valid
//   low_pkt_valid       pkt_valid fell while loading data
//   err, len_err        check mismatch / payload count != header length
//   hdr_addr            address field of the latched header
//   err_cnt             saturating count of bad packets
module router_reg_param #(
    parameter int unsigned DATA_W   = router_pkg::DATA_W,
    parameter int unsigned ADDR_W   = router_pkg::ADDR_W,
    parameter int unsigned CHK_MODE = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [ADDR_W-1:0] hdr_addr,
    output logic [CNT_W-1:0]  err_cnt
);
    import router_pkg::*;

    localparam int unsigned HLEN_W = DATA_W - ADDR_W;
    localparam int unsigned PC_W   = HLEN_W + 1;

    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] hold_q;
    logic [PC_W-1:0]   pay_cnt;

    logic              hdr_ok_c;
    logic              upd_c;
    logic              cap_ld_c;
    logic              cap_laf_c;
    logic              cap_c;
    logic              chk_bad_c;
    logic              len_bad_c;
    logic [DATA_W-1:0] chk_word_c;

    // The all-ones address is reserved; such a header is not latched.
    assign hdr_ok_c   = detect_add & pkt_valid & (data_in[ADDR_W-1:0] != {ADDR_W{1'b1}});
    assign upd_c      = ld_state & pkt_valid & ~full_state;
    // Check word arrives live, or was parked in hold_q when the FIFO stalled it.
    assign cap_ld_c   = ld_state & ~pkt_valid & ~fifo_full;
    assign cap_laf_c  = laf_state & low_pkt_valid & ~parity_done;
    assign cap_c      = cap_ld_c | cap_laf_c;
    assign chk_word_c = cap_ld_c ? data_in : hold_q;
    assign len_bad_c  = (pay_cnt != {1'b0, hdr_q[DATA_W-1:ADDR_W]});
    assign hdr_addr   = hdr_q[ADDR_W-1:0];

    router_chk_acc #(
        .DATA_W   (DATA_W),
        .CHK_MODE (CHK_MODE)
    ) u_chk (
        .clock      (clock),
        .resetn     (resetn),
        .clr        (detect_add),
        .lfd        (lfd_state),
        .upd        (upd_c),
        .hdr        (hdr_q),
        .data       (data_in),
        .word       (chk_word_c),
        .mismatch_c (chk_bad_c)
    );

    // Datapath and status registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q         <= '0;
            hold_q        <= '0;
            pay_cnt       <= '0;
            dout          <= '0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
            err_cnt       <= '0;
        end else begin
            if (hdr_ok_c) begin
                hdr_q <= data_in;
            end
            if (ld_state & fifo_full) begin
                hold_q <= data_in;
            end

            if (lfd_state) begin
                dout <= hdr_q;
            end else if (ld_state & ~fifo_full) begin
                dout <= data_in;
            end else if (laf_state) begin
                dout <= hold_q;
            end

            if (detect_add) begin
                pay_cnt <= '0;
            end else if (upd_c && (pay_cnt != {PC_W{1'b1}})) begin
                pay_cnt <= pay_cnt + PC_W'(1);
            end

            if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
            end else if (ld_state & ~pkt_valid) begin
                low_pkt_valid <= 1'b1;
            end

            // A new header takes precedence over a coincident capture.
            if (detect_add) begin
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else if (cap_c) begin
                parity_done <= 1'b1;
                err         <= chk_bad_c;
                len_err     <= len_bad_c;
                if ((chk_bad_c | len_bad_c) && (err_cnt != {CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
module tb_router_reg_param;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       rst_int_reg;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;

    logic [7:0] dout,   c_dout;
    logic       parity_done, c_parity_done;
    logic       low_pkt_valid, c_low_pkt_valid;
    logic       err,    c_err;
    logic       len_err, c_len_err;
    logic [1:0] hdr_addr, c_hdr_addr;
    logic [7:0] err_cnt, c_err_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] pay [8];
    logic [7:0] cw;

    always #5 clock = ~clock;

    router_reg_param #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0), .CNT_W(8)) u_dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .full_state(full_state),
        .laf_state(laf_state), .dout(dout), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err),
        .hdr_addr(hdr_addr), .err_cnt(err_cnt)
    );

    router_reg_param #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(1), .CNT_W(8)) u_dut_crc (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .full_state(full_state),
        .laf_state(laf_state), .dout(c_dout), .parity_done(c_parity_done),
        .low_pkt_valid(c_low_pkt_valid), .err(c_err), .len_err(c_len_err),
        .hdr_addr(c_hdr_addr), .err_cnt(c_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-8 reference, poly 0x07, MSB-first.
    function automatic logic [7:0] crc_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0; rst_int_reg = 1'b0;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
        full_state = 1'b0; laf_state = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_pd"}, parity_done, 0);
        check({tag, "_lpv"}, low_pkt_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_len_err"}, len_err, 0);
        check({tag, "_addr"}, hdr_addr, 0);
        check({tag, "_cnt"}, err_cnt, 0);
        check({tag, "_c_dout"}, c_dout, 0);
        check({tag, "_c_lpv"}, c_low_pkt_valid, 0);
        check({tag, "_c_cnt"}, c_err_cnt, 0);
    endtask

    // Drive one packet; stall_at selects a payload index that hits a full FIFO (-1 = none).
    task automatic send_pkt(input logic [7:0] hdr, input int n, input int stall_at, input logic [7:0] chkw);
        logic [7:0] prev;
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
        tick();
        detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h00;
        tick();
        check("lfd_dout", dout, hdr);
        prev = hdr;
        lfd_state = 1'b0; ld_state = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = pay[i];
            if (i == stall_at) begin
                fifo_full = 1'b1;
                tick();
                check("stall_dout_held", dout, prev);
                ld_state = 1'b0; full_state = 1'b1;
                tick();
                tick();
                full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
                tick();
                check("laf_dout", dout, pay[i]);
                laf_state = 1'b0; ld_state = 1'b1;
            end else begin
                tick();
                check("ld_dout", dout, pay[i]);
            end
            prev = pay[i];
        end
        pkt_valid = 1'b0; data_in = chkw;
        check("pd_before_cap", parity_done, 0);
        tick();
        ld_state = 1'b0; data_in = 8'h00;
        check("lpv_set", low_pkt_valid, 1);
    endtask

    task automatic end_pkt();
        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        check("lpv_cleared", low_pkt_valid, 0);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        #12;
        check_all_zero("por");
        resetn = 1'b1;
        tick();

        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        pay[4] = 8'h05; pay[5] = 8'h00; pay[6] = 8'h00; pay[7] = 8'h00;

        // Good XOR packet: 16^01^02^03^04^05 = 17
        send_pkt(8'h16, 5, -1, 8'h17);
        check("good_pd", parity_done, 1);
        check("good_err", err, 0);
        check("good_len_err", len_err, 0);
        check("good_addr", hdr_addr, 2);
        check("good_cnt", err_cnt, 0);
        end_pkt();
        check("good_pd_held", parity_done, 1);

        // Bad check word
        send_pkt(8'h16, 5, -1, 8'h2E);
        check("badchk_pd", parity_done, 1);
        check("badchk_err", err, 1);
        check("badchk_len_err", len_err, 0);
        check("badchk_cnt", err_cnt, 1);
        end_pkt();

        // Short packet: 4 payload words, check 16^01^02^03^04 = 12
        send_pkt(8'h16, 4, -1, 8'h12);
        check("short_err", err, 0);
        check("short_len_err", len_err, 1);
        check("short_cnt", err_cnt, 2);
        end_pkt();

        // FIFO full on payload 03; stall must not disturb the check
        send_pkt(8'h16, 5, 2, 8'h17);
        check("stall_pd", parity_done, 1);
        check("stall_err", err, 0);
        check("stall_len_err", len_err, 0);
        check("stall_cnt", err_cnt, 2);
        end_pkt();

        // Zero-length header: len 0, addr 2, check = header itself
        send_pkt(8'h02, 0, -1, 8'h02);
        check("zlen_pd", parity_done, 1);
        check("zlen_err", err, 0);
        check("zlen_len_err", len_err, 0);
        check("zlen_cnt", err_cnt, 2);
        end_pkt();

        // Async reset in the middle of the payload
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h16;
        tick();
        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h01;
        tick();
        data_in = 8'h02;
        tick();
        #2 resetn = 1'b0;
        #1 check_all_zero("midrst");
        #2 resetn = 1'b1;
        idle_inputs();
        tick();
        send_pkt(8'h16, 5, -1, 8'h17);
        check("postrst_pd", parity_done, 1);
        check("postrst_err", err, 0);
        check("postrst_len_err", len_err, 0);
        check("postrst_cnt", err_cnt, 0);
        end_pkt();

        // CRC-8 instance
        cw = crc_byte(8'h00, 8'h16);
        for (int i = 0; i < 5; i++) cw = crc_byte(cw, pay[i]);
        send_pkt(8'h16, 5, -1, cw);
        check("crc_pd", c_parity_done, 1);
        check("crc_err", c_err, 0);
        check("crc_len_err", c_len_err, 0);
        end_pkt();
        send_pkt(8'h16, 5, -1, cw ^ 8'h01);
        check("crc_bitflip_err", c_err, 1);
        end_pkt();

        // Invalid header (addr 3): latched header must stay
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h17;
        tick();
        detect_add = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
        check("inv_hdr_addr", hdr_addr, 2);
        check("inv_hdr_c_addr", c_hdr_addr, 2);
        check("inv_hdr_pd_clr", c_parity_done, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
